panda_pc_unit: RTL
==================

PANDA_PC_UNIT -- requirements
Module: panda_pc_unit

Interface
REQ-001 SHALL have parameter Width, default 32, meaning PC and target width in bits (at least 8).
REQ-002 SHALL have parameter ResetVector, default 32'h0000_0000, meaning PC value after reset.
REQ-003 SHALL have parameter TrapVector, default 32'h0000_0100, meaning PC loaded on trap.
REQ-004 SHALL have parameter RasDepth, default 4, meaning return-address-stack entries (power of two, at least 2).
REQ-005 SHALL provide ports, with one clock and an asynchronous, active-high reset:
  clk_i  in  1  clock, rising edge
  rst_i  in  1  asynchronous active-high reset
  stall_i  in  1  hold PC (increment suppressed)
  branch_i  in  1  take branch_target_i
  branch_target_i  in  Width  branch destination
  jump_i  in  1  take jump_target_i
  jump_target_i  in  Width  jump destination
  call_i  in  1  qualifies jump_i as call (push return address)
  ret_i  in  1  return: target is RAS top
  trap_i  in  1  enter trap
  mret_i  in  1  return from trap to EPC
  pc_o  out  Width  current PC
  pc_inc_o  out  Width  pc_o + 4, combinational
  epc_o  out  Width  saved exception PC
  misaligned_o  out  1  registered one-cycle pulse, rejected misaligned target
  ras_empty_o  out  1  RAS holds no entries
  ras_full_o  out  1  RAS holds RasDepth entries

Function
REQ-006 SHALL select next PC by fixed priority: trap_i > mret_i > ret_i > jump_i > branch_i > stall_i > increment.
REQ-007 SHALL apply every redirect (trap, mret, ret, jump, branch), even with stall_i high; stall_i alone holds pc_o.
REQ-008 SHALL update pc_o on the clock edge after the selecting inputs are sampled (one-cycle latency); no combinational input-to-pc_o path.
REQ-009 SHALL compute pc_inc_o modulo 2^Width; 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-010 SHALL on trap_i load pc_o with TrapVector and epc_o with the current pc_o in the same edge.
REQ-011 SHALL on mret_i (no trap) load pc_o with epc_o; epc_o unchanged.
REQ-012 SHALL on accepted ret_i with RAS non-empty load pc_o with RAS top and pop one entry.
REQ-013 SHALL on ret_i with RAS empty load pc_o with pc_inc_o; no pointer change.
REQ-014 SHALL on accepted jump_i with call_i push pc_inc_o onto RAS; call_i without jump_i is ignored.
REQ-015 SHALL when pushing into a full RAS overwrite the oldest entry; count stays RasDepth.
REQ-016 SHALL when the selected jump, branch or ret target has bits [1:0] non-zero, hold pc_o, leave RAS unchanged, and pulse misaligned_o high for exactly the next cycle.
REQ-017 SHALL never flag trap, mret or increment sources as misaligned.
REQ-018 SHALL leave RAS and epc_o unchanged on trap_i and mret_i, apart from REQ-010.
REQ-019 SHALL derive ras_empty_o and ras_full_o from a registered entry count (0..RasDepth).

Reset
REQ-020 SHALL on rst_i, asynchronously: pc_o = ResetVector, epc_o = 0, misaligned_o = 0, RAS count = 0 (ras_empty_o = 1, ras_full_o = 0), RAS pointer = 0.
REQ-021 SHALL, on rst_i asserted mid-operation, discard any pending redirect; the first post-reset update uses inputs sampled at the first edge after release.
REQ-022 SHALL not reset RAS storage contents; only pointer and count.

Structure
REQ-023 SHALL place PC-source select enum (PcTrap, PcMret, PcRet, PcJump, PcBranch, PcHold, PcInc) and the instruction-alignment constant in shared package panda_pkg.
REQ-024 SHALL implement the return-address stack as sub-module panda_ras (parameters Width, Depth; push, pop, data, empty, full).

Verification
REQ-025 Reset: assert rst_i mid-cycle, release -> pc_o 0x0 immediately; 0x4, 0x8, 0xC on subsequent edges; ras_empty_o = 1.
REQ-026 Branch vs stall: at pc 0x8, stall_i = 1 for 2 cycles -> pc_o holds 0x8; stall_i = 1 with branch_i = 1, target 0x18 -> pc_o 0x18 next edge.
REQ-027 Trap/mret: trap_i at pc 0x20 with jump_i = 1 -> pc_o 0x100, epc_o 0x20; mret_i later -> pc_o 0x20.
REQ-028 RAS: call jumps to 0x40, 0x80, 0xC0, 0x200, 0x300 with pc_inc 0x14, 0x44, 0x84, 0xC4, 0x204 -> ras_full_o after 4th; five rets -> 0x204, 0xC4, 0x84, 0x44, then empty fall-through to pc_inc.
REQ-029 Misaligned: jump_i target 0x3A at pc 0x10 -> pc_o stays 0x10, misaligned_o high one cycle, RAS count unchanged even with call_i = 1.
REQ-030 Wrap: pc 0xFFFF_FFFC with no redirect -> pc_o 0x0000_0000 next edge.

Source files
------------

// File: rtl/panda_pkg.sv
// rtl/panda_pkg.sv - shared PC-source encoding and instruction alignment constants
package panda_pkg;

    localparam int unsigned InstrAlignBits = 2;
    localparam int unsigned InstrBytes     = 4;

    typedef enum logic [2:0] {
        PcTrap,
        PcMret,
        PcRet,
        PcJump,
        PcBranch,
        PcHold,
        PcInc
    } pc_sel_e;

endpackage

// File: rtl/panda_ras.sv
// rtl/panda_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
module panda_ras #(
    parameter int Width = 32,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] push_data,
    output logic [Width-1:0] top_data,
    output logic             empty,
    output logic             full
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  ptr;
    logic [CntW-1:0]  count;

    // ptr names the next free slot, so the top lives one below it
    assign top_data = mem[ptr - PtrW'(1)];
    assign empty    = (count == '0);
    assign full     = (count == CntW'(Depth));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PtrW'(1);
            if (!full) begin
                count <= count + CntW'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= ptr - PtrW'(1);
            count <= count - CntW'(1);
        end
    end

endmodule

// File: rtl/panda_pc_unit.sv
// rtl/panda_pc_unit.sv - program counter with fixed-priority redirects, trap EPC and return-address stack
module panda_pc_unit
    import panda_pkg::*;
#(
    parameter int               Width       = 32,
    parameter logic [Width-1:0] ResetVector = 32'h0000_0000,
    parameter logic [Width-1:0] TrapVector  = 32'h0000_0100,
    parameter int               RasDepth    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic [Width-1:0] branch_target_i,
    input  logic             jump_i,
    input  logic [Width-1:0] jump_target_i,
    input  logic             call_i,
    input  logic             ret_i,
    input  logic             trap_i,
    input  logic             mret_i,
    output logic [Width-1:0] pc_o,
    output logic [Width-1:0] pc_inc_o,
    output logic [Width-1:0] epc_o,
    output logic             misaligned_o,
    output logic             ras_empty_o,
    output logic             ras_full_o
);
    pc_sel_e          sel;
    logic [Width-1:0] ras_top;
    logic [Width-1:0] target;
    logic [Width-1:0] next_pc;
    logic             check_align;
    logic             misaligned;
    logic             ras_push;
    logic             ras_pop;

    assign pc_inc_o = pc_o + Width'(InstrBytes);

    always_comb begin
        sel = PcInc;
        if (trap_i)        sel = PcTrap;
        else if (mret_i)   sel = PcMret;
        else if (ret_i)    sel = PcRet;
        else if (jump_i)   sel = PcJump;
        else if (branch_i) sel = PcBranch;
        else if (stall_i)  sel = PcHold;
    end

    always_comb begin
        target      = pc_inc_o;
        check_align = 1'b0;
        unique case (sel)
            PcTrap:   target = TrapVector;
            PcMret:   target = epc_o;
            PcRet: begin
                // an empty stack falls through to the sequential PC, which is never flagged
                if (!ras_empty_o) begin
                    target      = ras_top;
                    check_align = 1'b1;
                end
            end
            PcJump: begin
                target      = jump_target_i;
                check_align = 1'b1;
            end
            PcBranch: begin
                target      = branch_target_i;
                check_align = 1'b1;
            end
            PcHold:   target = pc_o;
            default:  target = pc_inc_o;
        endcase
        misaligned = check_align && (target[InstrAlignBits-1:0] != '0);
        next_pc    = misaligned ? pc_o : target;
        ras_push   = (sel == PcJump) && call_i && !misaligned;
        ras_pop    = (sel == PcRet) && !ras_empty_o && !misaligned;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_o         <= ResetVector;
            epc_o        <= '0;
            misaligned_o <= 1'b0;
        end else begin
            pc_o         <= next_pc;
            misaligned_o <= misaligned;
            if (sel == PcTrap) begin
                epc_o <= pc_o;
            end
        end
    end

    panda_ras #(
        .Width (Width),
        .Depth (RasDepth)
    ) u_ras (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc_o),
        .top_data  (ras_top),
        .empty     (ras_empty_o),
        .full      (ras_full_o)
    );

endmodule
